// File: rtl/bb_oth_dev_pkg.sv
// Shared definitions for the oth-bus peripheral: register offsets, STATUS/IE bit
// positions and the STATUS word packing helper.
package bb_oth_dev_pkg;

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_TX_DATA = 3'd1,
    REG_RX_DATA = 3'd2,
    REG_TIMER   = 3'd3,
    REG_COMPARE = 3'd4,
    REG_SCRATCH = 3'd5
  } oth_reg_e;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_HIT        = 4;
  localparam int unsigned ST_TX_OVF     = 5;
  localparam int unsigned ST_RX_UDF     = 6;
  localparam int unsigned ST_IE_LSB     = 8;
  localparam int unsigned ST_TX_CNT_LSB = 16;
  localparam int unsigned ST_RX_CNT_LSB = 24;

  localparam int unsigned IE_HIT = 0;
  localparam int unsigned IE_RX  = 1;
  localparam int unsigned IE_TX  = 2;

  typedef struct packed {
    logic rx_udf;
    logic tx_ovf;
    logic hit;
  } sticky_t;

  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_empty,
    input logic       rx_full,
    input sticky_t    sticky,
    input logic [2:0] ie,
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_TX_FULL]              = tx_full;
    s[ST_TX_EMPTY]             = tx_empty;
    s[ST_RX_EMPTY]             = rx_empty;
    s[ST_RX_FULL]              = rx_full;
    s[ST_HIT]                  = sticky.hit;
    s[ST_TX_OVF]               = sticky.tx_ovf;
    s[ST_RX_UDF]               = sticky.rx_udf;
    s[ST_IE_LSB +: 3]          = ie;
    s[ST_TX_CNT_LSB +: 8]      = tx_cnt;
    s[ST_RX_CNT_LSB +: 8]      = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/bb_oth_dev_if.sv
// Core-side "oth" device bus: one-cycle read/write strobes, word address, data.
interface bb_oth_dev_if
  import bb_oth_dev_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  oen;
  logic                  ien;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output oen, ien, addr, wdata, input rdata);
  modport slave  (input oen, ien, addr, wdata, output rdata);

endinterface

// File: rtl/bb_sync_fifo.sv
// Single-clock FIFO with occupancy counter; push while full and pop while empty
// are ignored, both decided on the pre-edge count.
module bb_sync_fifo
  import bb_oth_dev_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by the counter.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bb_oth_dev.sv
// oth-bus responder: TX/RX byte FIFOs, free-running timer with compare,
// scratch register, sticky status and level interrupt.
module bb_oth_dev
  import bb_oth_dev_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]   BASE_ADDR  = 'h100,
  parameter int unsigned             FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  bb_oth_dev_if.slave oth,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic      sel, rd, wr;
  oth_reg_e  reg_sel;

  logic          tx_push, tx_pop, tx_full, tx_empty, tx_wr;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_rd;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  logic [DATA_WIDTH-1:0] timer_q, timer_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  sticky_t               sticky_q, sticky_d, sticky_clr;
  logic [2:0]            ie_q, ie_d;

  assign sel     = (oth.addr[DATA_WIDTH-1:3] == BASE_ADDR[DATA_WIDTH-1:3]);
  assign reg_sel = oth_reg_e'(oth.addr[2:0]);
  assign rd      = sel & oth.oen;
  assign wr      = sel & oth.ien;

  assign tx_wr   = wr & (reg_sel == REG_TX_DATA);
  assign tx_push = tx_wr & ~tx_full;
  assign tx_pop  = ~tx_empty & i_tx_ready;
  assign rx_rd   = rd & (reg_sel == REG_RX_DATA);
  assign rx_pop  = rx_rd & ~rx_empty;
  assign rx_push = i_rx_valid & ~rx_full;

  assign o_tx_valid = ~tx_empty;
  assign o_tx_data  = tx_head;
  assign o_rx_ready = ~rx_full;
  assign o_irq      = (sticky_q.hit & ie_q[IE_HIT]) |
                      (~rx_empty    & ie_q[IE_RX])  |
                      (tx_empty     & ie_q[IE_TX]);

  bb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (oth.wdata[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  bb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (i_rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_comb begin
    timer_d    = timer_q + DATA_WIDTH'(1);
    compare_d  = compare_q;
    scratch_d  = scratch_q;
    ie_d       = ie_q;
    sticky_clr = '0;
    if (wr) begin
      case (reg_sel)
        REG_STATUS: begin
          sticky_clr = sticky_t'(oth.wdata[ST_RX_UDF:ST_HIT]);
          ie_d       = oth.wdata[ST_IE_LSB +: 3];
        end
        // A written timer value stands for the write cycle itself, so it advances at the same edge.
        REG_TIMER:   timer_d   = oth.wdata + DATA_WIDTH'(1);
        REG_COMPARE: compare_d = oth.wdata;
        REG_SCRATCH: scratch_d = oth.wdata;
        default: ;
      endcase
    end
    // New events override a same-edge write-one-to-clear.
    sticky_d.hit    = (timer_q == compare_q) | (sticky_q.hit    & ~sticky_clr.hit);
    sticky_d.tx_ovf = (tx_wr & tx_full)      | (sticky_q.tx_ovf & ~sticky_clr.tx_ovf);
    sticky_d.rx_udf = (rx_rd & rx_empty)     | (sticky_q.rx_udf & ~sticky_clr.rx_udf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      compare_q <= '1;
      scratch_q <= '0;
      sticky_q  <= '0;
      ie_q      <= '0;
    end else begin
      timer_q   <= timer_d;
      compare_q <= compare_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      ie_q      <= ie_d;
    end
  end

  always_comb begin
    oth.rdata = '0;
    if (rd) begin
      case (reg_sel)
        REG_STATUS:  oth.rdata = DATA_WIDTH'(pack_status(tx_full, tx_empty, rx_empty, rx_full,
                                                         sticky_q, ie_q, 8'(tx_count), 8'(rx_count)));
        REG_RX_DATA: oth.rdata = rx_empty ? '0 : DATA_WIDTH'(rx_head);
        REG_TIMER:   oth.rdata = timer_q;
        REG_COMPARE: oth.rdata = compare_q;
        REG_SCRATCH: oth.rdata = scratch_q;
        default:     oth.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_oth_dev.sv
// Self-checking bench for bb_oth_dev: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_bb_oth_dev;

  localparam int unsigned DW   = 32;
  localparam logic [31:0] BASE = 32'h100;
  localparam int          D    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_tx_valid, i_tx_ready, i_rx_valid, o_rx_ready, o_irq;
  logic [7:0] o_tx_data, i_rx_data;

  always #5 clk = ~clk;

  bb_oth_dev_if #(.DATA_WIDTH(DW)) oth ();

  bb_oth_dev #(.DATA_WIDTH(DW), .BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .oth        (oth.slave),
    .o_tx_valid (o_tx_valid),
    .o_tx_data  (o_tx_data),
    .i_tx_ready (i_tx_ready),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_rx_ready (o_rx_ready),
    .o_irq      (o_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%08h, expected 'h%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [31:0] m_timer, m_cmp, m_scr;
  logic        m_hit, m_ovf, m_udf;
  logic [2:0]  m_ie;

  function automatic logic m_sel(input logic [31:0] a);
    return (a >> 3) == (BASE >> 3);
  endfunction

  function automatic logic [31:0] m_status();
    int tc = txq.size();
    int rc = rxq.size();
    return (rc << 24) + (tc << 16) + (32'(m_ie) << 8) + (32'(m_udf) << 6) + (32'(m_ovf) << 5)
         + (32'(m_hit) << 4) + (32'(rc == D) << 3) + (32'(rc == 0) << 2)
         + (32'(tc == 0) << 1) + 32'(tc == D);
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] a = oth.addr;
    if (!(oth.oen && m_sel(a))) return 32'h0;
    case (a % 8)
      0: return m_status();
      2: return (rxq.size() > 0) ? 32'(rxq[0]) : 32'h0;
      3: return m_timer;
      4: return m_cmp;
      5: return m_scr;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      txq.delete(); rxq.delete();
      m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_scr = 0;
      m_hit = 0; m_ovf = 0; m_udf = 0; m_ie = 0;
    end else begin : step
      int          tsz, rsz, off;
      logic        wr, rd, hit_new, ovf_new, udf_new;
      logic [31:0] wd;
      tsz = txq.size(); rsz = rxq.size();
      off = int'(oth.addr % 8);
      wr = oth.ien && m_sel(oth.addr);
      rd = oth.oen && m_sel(oth.addr);
      wd = oth.wdata;
      hit_new = (m_timer == m_cmp);
      ovf_new = 0; udf_new = 0;
      if (tsz > 0 && i_tx_ready) void'(txq.pop_front());
      if (wr && off == 1) begin
        if (tsz == D) ovf_new = 1; else txq.push_back(wd[7:0]);
      end
      if (rd && off == 2) begin
        if (rsz > 0) void'(rxq.pop_front()); else udf_new = 1;
      end
      if (i_rx_valid && rsz < D) rxq.push_back(i_rx_data);
      if (wr && off == 0) begin
        m_ie = wd[10:8];
        if (wd[4]) m_hit = 0;
        if (wd[5]) m_ovf = 0;
        if (wd[6]) m_udf = 0;
      end
      m_hit = m_hit | hit_new;
      m_ovf = m_ovf | ovf_new;
      m_udf = m_udf | udf_new;
      m_timer = (wr && off == 3) ? wd + 1 : m_timer + 1;
      if (wr && off == 4) m_cmp = wd;
      if (wr && off == 5) m_scr = wd;
    end
  end

  always @(negedge clk) begin
    check("tx_valid", 32'(o_tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", 32'(o_tx_data), 32'(txq[0]));
    check("rx_ready", 32'(o_rx_ready), 32'(rxq.size() < D));
    check("irq", 32'(o_irq), 32'((m_hit & m_ie[0]) | ((rxq.size() != 0) & m_ie[1]) | ((txq.size() == 0) & m_ie[2])));
    check("rdata", oth.rdata, m_rdata());
  end

  // ---------------- stimulus ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    oth.addr = a; oth.wdata = v; oth.ien = 1'b1;
    @(posedge clk); #1;
    oth.ien = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    oth.addr = a; oth.oen = 1'b1;
    @(negedge clk); d = oth.rdata;
    @(posedge clk); #1;
    oth.oen = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          n;
    logic        found;

    rst = 1'b1; oth.oen = 0; oth.ien = 0; oth.addr = 0; oth.wdata = 0;
    i_tx_ready = 0; i_rx_valid = 0; i_rx_data = 0;
    @(negedge clk);
    check("rst_tx_valid", 32'(o_tx_valid), 0);
    check("rst_rx_ready", 32'(o_rx_ready), 1);
    check("rst_irq", 32'(o_irq), 0);
    check("rst_rdata", oth.rdata, 0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: reset pulse mid-run discards state
    bus_write(BASE + 1, 32'h55);
    bus_write(BASE + 5, 32'h77);
    bus_write(BASE + 0, 32'h300);
    rst = 1'b1; #2;
    check("midrst_tx_valid", 32'(o_tx_valid), 0);
    check("midrst_rx_ready", 32'(o_rx_ready), 1);
    check("midrst_irq", 32'(o_irq), 0);
    @(posedge clk); #1; rst = 1'b0;
    bus_read(BASE + 0, d);  check("status_after_rst", d, 32'h0000_0006);
    bus_read(BASE + 5, d);  check("scratch_after_rst", d, 0);

    // 2: TX fill, overflow, drain
    for (int k = 0; k < 8; k++) bus_write(BASE + 1, 32'h41 + k);
    bus_read(BASE + 0, d);
    check("tx_full_bit", d & 1, 1);
    check("tx_cnt", (d >> 16) & 8'hFF, 8);
    bus_write(BASE + 1, 32'h49);
    bus_read(BASE + 0, d);  check("tx_ovf_bit", (d >> 5) & 1, 1);
    bus_read(BASE + 1, d);  check("tx_data_read", d, 0);
    i_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("drain_valid", 32'(o_tx_valid), 1);
      check("drain_byte", 32'(o_tx_data), 32'h41 + k);
      @(posedge clk); #1;
    end
    i_tx_ready = 1'b0;
    @(negedge clk); check("drained_empty", 32'(o_tx_valid), 0);
    @(posedge clk); #1;
    bus_write(BASE + 0, 32'h20);

    // 3: RX receive, underflow, W1C
    for (int k = 0; k < 3; k++) begin
      i_rx_valid = 1'b1; i_rx_data = 8'hA0 + 8'(k);
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 2, d); check("rx_byte", d, 32'hA0 + k);
    end
    bus_read(BASE + 2, d);  check("rx_empty_read", d, 0);
    bus_read(BASE + 0, d);  check("rx_udf_set", (d >> 6) & 1, 1);
    bus_write(BASE + 0, 32'h40);
    bus_read(BASE + 0, d);  check("rx_udf_clr", (d >> 6) & 1, 0);

    // 4: timer/compare interrupt. Timer reads 10+k in the k-th cycle after the
    // write cycle, matches 20 at k=10, so irq is first seen at k=11.
    bus_write(BASE + 3, 10);
    n = 1;
    bus_write(BASE + 4, 20); n++;
    bus_write(BASE + 0, 32'h100); n++;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_irq) found = 1;
      else begin @(posedge clk); #1; n++; end
    end
    @(posedge clk); #1;
    check("irq_rise_cycle", found ? n : 0, 11);
    bus_write(BASE + 0, 32'h110);
    @(negedge clk); check("irq_cleared", 32'(o_irq), 0);
    @(posedge clk); #1;
    bus_write(BASE + 0, 32'h0);

    // 5: RX full with concurrent offer and pop
    for (int k = 0; k < 8; k++) begin
      i_rx_valid = 1'b1; i_rx_data = 8'hB0 + 8'(k);
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b0;
    bus_read(BASE + 0, d);
    check("rx_full_bit", (d >> 3) & 1, 1);
    check("rx_cnt_full", (d >> 24) & 8'hFF, 8);
    i_rx_valid = 1'b1; i_rx_data = 8'hC0;
    oth.addr = BASE + 2; oth.oen = 1'b1;
    @(negedge clk);
    check("full_rx_ready", 32'(o_rx_ready), 0);
    check("full_pop_byte", oth.rdata, 32'hB0);
    @(posedge clk); #1;
    oth.oen = 1'b0; i_rx_valid = 1'b0;
    bus_read(BASE + 0, d);  check("rx_cnt_after_pop", (d >> 24) & 8'hFF, 7);
    for (int k = 1; k < 8; k++) begin
      bus_read(BASE + 2, d); check("rx_order", d, 32'hB0 + k);
    end
    bus_read(BASE + 0, d);  check("rx_drained", (d >> 2) & 1, 1);

    // 6: decode, scratch, timer wrap, reserved offsets
    oth.addr = 32'h205; oth.wdata = 32'h1234; oth.oen = 1'b1; oth.ien = 1'b1;
    @(negedge clk); check("unsel_rdata", oth.rdata, 0);
    @(posedge clk); #1; oth.oen = 1'b0; oth.ien = 1'b0;
    bus_read(BASE + 5, d);  check("unsel_no_write", d, 0);
    bus_write(BASE + 5, 32'hDEAD_BEEF);
    bus_read(BASE + 5, d);  check("scratch_rt", d, 32'hDEAD_BEEF);
    oth.addr = BASE + 5; oth.wdata = 32'hCAFE_F00D; oth.oen = 1'b1; oth.ien = 1'b1;
    @(negedge clk); check("rw_same_cycle_old", oth.rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1; oth.oen = 1'b0; oth.ien = 1'b0;
    bus_read(BASE + 5, d);  check("rw_same_cycle_new", d, 32'hCAFE_F00D);
    bus_write(BASE + 3, 32'hFFFF_FFFF);
    bus_read(BASE + 3, d);  check("timer_wrap", d, 0);
    bus_read(BASE + 6, d);  check("off6_zero", d, 0);
    bus_read(BASE + 7, d);  check("off7_zero", d, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
